// File: rtl/psram_bus_bridge.sv
// CPU valid/ready bus to QSPI PSRAM controller command bridge: posted writes, stalled lane-aligned reads.
// Optional read watchdog enabled by defining PSRAM_BRIDGE_TIMEOUT_EN.
module psram_bus_bridge #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_valid,
    input  logic        bus_we,
    input  logic [1:0]  bus_size,
    input  logic [23:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic        bus_ready,
    output logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic [1:0]  cmd_req,
    input  logic        cmd_ack,
    output logic [1:0]  cmd_size,
    output logic [23:0] cmd_addr,
    output logic [31:0] cmd_din,
    input  logic [31:0] cmd_dout,
    input  logic        data_valid
);

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;
    localparam logic [1:0] REQ_NOP = 2'b00;
    localparam logic [1:0] REQ_WR  = 2'b01;
    localparam logic [1:0] REQ_RD  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RWAIT, S_RESP} state_t;

    state_t          state_q, state_n;
    logic            bus_ready_n, bus_err_n;
    logic [DW-1:0]   bus_rdata_n, cmd_din_n;
    logic [1:0]      cmd_req_n, cmd_size_n;
    logic [AW-1:0]   cmd_addr_n;
    logic [DW-1:0]   resp_data_q, resp_data_n;
    logic            resp_err_q, resp_err_n;
    logic            misaligned_c;
    logic [DW-1:0]   rdata_aligned_c;

`ifdef PSRAM_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT - 1);
    logic [15:0] tmo_q, tmo_n;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    always_comb begin
        case (bus_size)
            2'b01:   misaligned_c = bus_addr[0];
            2'b10:   misaligned_c = (bus_addr[1:0] != 2'b00);
            2'b11:   misaligned_c = 1'b1;
            default: misaligned_c = 1'b0;
        endcase
    end

    // Controller returns the addressed byte in lane 0; move it to its bus lane.
    assign rdata_aligned_c = DW'(cmd_dout << {cmd_addr[1:0], 3'b000});

    always_comb begin
        state_n     = state_q;
        bus_ready_n = 1'b0;
        bus_err_n   = 1'b0;
        bus_rdata_n = bus_rdata;
        cmd_req_n   = cmd_req;
        cmd_size_n  = cmd_size;
        cmd_addr_n  = cmd_addr;
        cmd_din_n   = cmd_din;
        resp_data_n = resp_data_q;
        resp_err_n  = resp_err_q;
`ifdef PSRAM_BRIDGE_TIMEOUT_EN
        tmo_n       = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                // bus_ready high means the CPU is still completing the previous handshake
                if (bus_valid && !bus_ready) begin
                    if (misaligned_c) begin
                        resp_err_n  = 1'b1;
                        resp_data_n = '0;
                        state_n     = S_RESP;
                    end else begin
                        cmd_size_n = bus_size;
                        cmd_addr_n = bus_addr;
                        cmd_din_n  = bus_wdata;
                        state_n    = S_REQ;
                        if (bus_we) begin
                            cmd_req_n   = REQ_WR;
                            bus_ready_n = 1'b1;
                        end else begin
                            cmd_req_n = REQ_RD;
                        end
                    end
                end
            end
            S_REQ: begin
                if (cmd_ack) begin
                    cmd_req_n = REQ_NOP;
                    state_n   = (cmd_req == REQ_WR) ? S_IDLE : S_RWAIT;
`ifdef PSRAM_BRIDGE_TIMEOUT_EN
                    tmo_n     = '0;
`endif
                end
            end
            S_RWAIT: begin
                if (data_valid) begin
                    resp_data_n = rdata_aligned_c;
                    resp_err_n  = 1'b0;
                    state_n     = S_RESP;
                end
`ifdef PSRAM_BRIDGE_TIMEOUT_EN
                else if (tmo_q == TMO_LIMIT) begin
                    resp_data_n = 32'hDEADBEEF;
                    resp_err_n  = 1'b1;
                    state_n     = S_RESP;
                end else begin
                    tmo_n = tmo_q + 16'd1;
                end
`endif
            end
            S_RESP: begin
                bus_ready_n = 1'b1;
                bus_err_n   = resp_err_q;
                bus_rdata_n = resp_data_q;
                state_n     = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            bus_ready   <= 1'b0;
            bus_err     <= 1'b0;
            bus_rdata   <= '0;
            cmd_req     <= REQ_NOP;
            cmd_size    <= 2'b00;
            cmd_addr    <= '0;
            cmd_din     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
`ifdef PSRAM_BRIDGE_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_n;
            bus_ready   <= bus_ready_n;
            bus_err     <= bus_err_n;
            bus_rdata   <= bus_rdata_n;
            cmd_req     <= cmd_req_n;
            cmd_size    <= cmd_size_n;
            cmd_addr    <= cmd_addr_n;
            cmd_din     <= cmd_din_n;
            resp_data_q <= resp_data_n;
            resp_err_q  <= resp_err_n;
`ifdef PSRAM_BRIDGE_TIMEOUT_EN
            tmo_q       <= tmo_n;
`endif
        end
    end

endmodule

// File: tb/tb_psram_bus_bridge.sv
// Directed self-checking bench for psram_bus_bridge.
module tb_psram_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_valid, bus_we;
    logic [1:0]  bus_size;
    logic [23:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic [1:0]  cmd_req;
    logic        cmd_ack;
    logic [1:0]  cmd_size;
    logic [23:0] cmd_addr;
    logic [31:0] cmd_din;
    logic [31:0] cmd_dout;
    logic        data_valid;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr_issue = 0;
    int n_rd_issue = 0;
    int wr0, rd0;
    logic [1:0] prev_req = 2'b00;

    psram_bus_bridge #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd_size(cmd_size),
        .cmd_addr(cmd_addr), .cmd_din(cmd_din), .cmd_dout(cmd_dout),
        .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    // Counts each new command the controller would see.
    always @(posedge clk) begin
        if (cmd_req != prev_req && cmd_req == 2'b01) n_wr_issue++;
        if (cmd_req != prev_req && cmd_req == 2'b10) n_rd_issue++;
        prev_req = cmd_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(bus_ready), 32'd0);
        chk({tag, "_err"},   32'(bus_err),   32'd0);
        chk({tag, "_rdata"}, bus_rdata,      32'd0);
        chk({tag, "_req"},   32'(cmd_req),   32'd0);
        chk({tag, "_size"},  32'(cmd_size),  32'd0);
        chk({tag, "_addr"},  32'(cmd_addr),  32'd0);
        chk({tag, "_din"},   cmd_din,        32'd0);
    endtask

    initial begin
        reset = 1'b0; bus_valid = 0; bus_we = 0; bus_size = 0; bus_addr = 0;
        bus_wdata = 0; cmd_ack = 0; cmd_dout = 0; data_valid = 0;
        tick(); tick();
        chk_reset_vals("rst");
        reset = 1'b1;
        tick();

        // Dword write 0x000100 <- 0x11223344
        bus_valid = 1; bus_we = 1; bus_size = 2'b10; bus_addr = 24'h000100; bus_wdata = 32'h11223344;
        tick();
        chk("wr_ready", 32'(bus_ready), 32'd1);
        chk("wr_req",   32'(cmd_req),   32'd1);
        chk("wr_addr",  32'(cmd_addr),  32'h000100);
        chk("wr_din",   cmd_din,        32'h11223344);
        chk("wr_size",  32'(cmd_size),  32'd2);
        bus_valid = 0;
        tick();
        chk("wr_ready_pulse", 32'(bus_ready), 32'd0);
        chk("wr_req_held",    32'(cmd_req),   32'd1);
        chk("wr_din_held",    cmd_din,        32'h11223344);
        cmd_ack = 1;
        tick();
        cmd_ack = 0;
        chk("wr_req_clr", 32'(cmd_req), 32'd0);

        // Byte read 0x000203, controller returns 0xAB in lane 0
        bus_valid = 1; bus_we = 0; bus_size = 2'b00; bus_addr = 24'h000203;
        tick();
        chk("rdb_req",   32'(cmd_req),  32'd2);
        chk("rdb_addr",  32'(cmd_addr), 32'h000203);
        chk("rdb_ready", 32'(bus_ready), 32'd0);
        cmd_ack = 1;
        tick();
        cmd_ack = 0;
        chk("rdb_req_clr", 32'(cmd_req), 32'd0);
        cmd_dout = 32'h000000AB; data_valid = 1;
        tick();
        data_valid = 0;
        chk("rdb_ready_early", 32'(bus_ready), 32'd0);
        tick();
        chk("rdb_ready", 32'(bus_ready), 32'd1);
        chk("rdb_rdata", bus_rdata,      32'hAB000000);
        chk("rdb_err",   32'(bus_err),   32'd0);
        bus_valid = 0;
        tick();
        chk("rdb_one_pulse", 32'(bus_ready), 32'd0);
        chk("rdb_rdata_hold", bus_rdata,     32'hAB000000);

        // Misaligned word read at 0x000001
        bus_valid = 1; bus_we = 0; bus_size = 2'b01; bus_addr = 24'h000001;
        tick();
        chk("mis_ready_early", 32'(bus_ready), 32'd0);
        chk("mis_req0",        32'(cmd_req),   32'd0);
        tick();
        chk("mis_ready", 32'(bus_ready), 32'd1);
        chk("mis_err",   32'(bus_err),   32'd1);
        chk("mis_req1",  32'(cmd_req),   32'd0);
        bus_valid = 0;
        tick();
        chk("mis_ready_off", 32'(bus_ready), 32'd0);
        chk("mis_err_off",   32'(bus_err),   32'd0);
        chk("mis_req2",      32'(cmd_req),   32'd0);

        // Stray ack and data_valid while idle are ignored
        cmd_ack = 1; data_valid = 1; cmd_dout = 32'hFFFFFFFF;
        tick();
        cmd_ack = 0; data_valid = 0;
        chk("idle_ack_req",   32'(cmd_req),   32'd0);
        tick();
        chk("idle_dv_ready",  32'(bus_ready), 32'd0);

        // Posted write then read, write ack delayed 10 cycles
        wr0 = n_wr_issue; rd0 = n_rd_issue;
        bus_valid = 1; bus_we = 1; bus_size = 2'b10; bus_addr = 24'h000010; bus_wdata = 32'hCAFEF00D;
        tick();
        chk("raw_wr_ready", 32'(bus_ready), 32'd1);
        bus_we = 0; bus_addr = 24'h000020;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("raw_stall_req",   32'(cmd_req),   32'd1);
            chk("raw_stall_ready", 32'(bus_ready), 32'd0);
        end
        cmd_ack = 1;
        tick();
        cmd_ack = 0;
        chk("raw_wr_done", 32'(cmd_req), 32'd0);
        tick();
        chk("raw_rd_req",  32'(cmd_req),  32'd2);
        chk("raw_rd_addr", 32'(cmd_addr), 32'h000020);
        cmd_ack = 1;
        tick();
        cmd_ack = 0;
        cmd_dout = 32'h55667788; data_valid = 1;
        tick();
        data_valid = 0;
        tick();
        chk("raw_rd_ready", 32'(bus_ready), 32'd1);
        chk("raw_rd_data",  bus_rdata,      32'h55667788);
        bus_valid = 0;
        tick();
        chk("raw_wr_once", 32'(n_wr_issue - wr0), 32'd1);
        chk("raw_rd_once", 32'(n_rd_issue - rd0), 32'd1);

        // Read with two data_valid pulses: only the first counts
        bus_valid = 1; bus_we = 0; bus_size = 2'b10; bus_addr = 24'h000040;
        tick();
        cmd_ack = 1;
        tick();
        cmd_ack = 0;
        cmd_dout = 32'h12345678; data_valid = 1;
        tick();
        cmd_dout = 32'h9ABCDEF0;
        tick();
        data_valid = 0;
        chk("dv2_ready", 32'(bus_ready), 32'd1);
        chk("dv2_rdata", bus_rdata,      32'h12345678);
        bus_valid = 0;
        tick();
        chk("dv2_one_pulse", 32'(bus_ready), 32'd0);
        tick();
        chk("dv2_no_second", 32'(bus_ready), 32'd0);
        chk("dv2_rdata_hold", bus_rdata,     32'h12345678);

`ifdef PSRAM_BRIDGE_TIMEOUT_EN
        // Watchdog: no data_valid for TIMEOUT cycles
        bus_valid = 1; bus_we = 0; bus_size = 2'b10; bus_addr = 24'h000080;
        tick();
        cmd_ack = 1;
        tick();
        cmd_ack = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("tmo_wait", 32'(bus_ready), 32'd0);
        end
        tick();
        chk("tmo_ready", 32'(bus_ready), 32'd1);
        chk("tmo_rdata", bus_rdata,      32'hDEADBEEF);
        chk("tmo_err",   32'(bus_err),   32'd1);
        bus_valid = 0;
        tick();
`endif

        // Reset while waiting for read data drops the transaction
        bus_valid = 1; bus_we = 0; bus_size = 2'b01; bus_addr = 24'h000302;
        tick();
        cmd_ack = 1;
        tick();
        cmd_ack = 0;
        tick();
        reset = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        bus_valid = 0;
        tick();
        reset = 1'b1;
        data_valid = 1; cmd_dout = 32'h0000BEEF;
        tick();
        data_valid = 0;
        tick();
        chk("mid_rst_no_ready", 32'(bus_ready), 32'd0);
        chk("mid_rst_rdata",    bus_rdata,      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
